// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences the oversampling sampler, checks start/parity/stop
// and deserialises data LSB-first, reporting results as registered one-cycle pulses.
module uart_rx_ctrl #(
  parameter int Prescale_Width = 6,
  parameter int Data_Width     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_In,
  input  logic [Prescale_Width-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      Sampled_Bit,
  output logic [Prescale_Width-1:0] Edge_Cnt,
  output logic                      Data_Samp_En,
  output logic [Data_Width-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stp_Err,
  output logic                      Strt_Glitch
);

  localparam int BitCntW = $clog2(Data_Width + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [BitCntW-1:0]    r_bit_cnt;
  logic [Data_Width-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_mis;
  logic                  w_bit_end;

  // Decisions wait for the last oversample so the sampler's vote has settled.
  assign w_bit_end = (Edge_Cnt == Prescale - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_mis    <= 1'b0;
      Edge_Cnt     <= '0;
      Data_Samp_En <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Par_Err      <= 1'b0;
      Stp_Err      <= 1'b0;
      Strt_Glitch  <= 1'b0;
    end else begin
      // NOTE: pulses default low each cycle; a later assignment in this block wins,
      // so any branch below that raises one produces exactly a one-cycle pulse.
      Data_Valid  <= 1'b0;
      Par_Err     <= 1'b0;
      Stp_Err     <= 1'b0;
      Strt_Glitch <= 1'b0;

      if (r_state == S_IDLE) begin
        Edge_Cnt <= '0;
      end else if (w_bit_end) begin
        Edge_Cnt  <= '0;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        Edge_Cnt <= Edge_Cnt + 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (!RX_In) begin
            r_state      <= S_START;
            r_par_en     <= PAR_EN;
            r_par_typ    <= PAR_TYP;
            r_bit_cnt    <= '0;
            r_par_mis    <= 1'b0;
            Data_Samp_En <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            if (Sampled_Bit) begin
              r_state      <= S_IDLE;
              Strt_Glitch  <= 1'b1;
              Data_Samp_En <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            // Bit counter is 1 for the first data bit because the start bit counted as 0.
            r_shift <= {Sampled_Bit, r_shift[Data_Width-1:1]};
            if (r_bit_cnt == BitCntW'(Data_Width)) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_par_mis <= ((^r_shift) ^ r_par_typ) != Sampled_Bit;
            r_state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_state      <= S_IDLE;
            Data_Samp_En <= 1'b0;
            Stp_Err      <= ~Sampled_Bit;
            Par_Err      <= r_par_mis;
            if (Sampled_Bit && !r_par_mis) begin
              P_DATA     <= r_shift;
              Data_Valid <= 1'b1;
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          Data_Samp_En <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a simple mid-bit sampler model drives Sampled_Bit,
// and frame outcomes are predicted from frame timing and parity rules.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       sampled_bit = 1'b1;
  logic [5:0] edge_cnt;
  logic       dse;
  logic [7:0] p_data;
  logic       dv, pe_o, se_o, sg_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_end = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct packed {
    logic [31:0] cyc;
    logic        dv;
    logic        pe;
    logic        se;
    logic        sg;
    logic [7:0]  pd;
  } ev_t;

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] d;
    bit         flip;
    bit         stop;
    bit         exp_dv;
    bit         exp_pe;
    bit         exp_se;
  } vec_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  uart_rx_ctrl #(.Prescale_Width(6), .Data_Width(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_In        (rx),
    .Prescale     (prescale),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .Sampled_Bit  (sampled_bit),
    .Edge_Cnt     (edge_cnt),
    .Data_Samp_En (dse),
    .P_DATA       (p_data),
    .Data_Valid   (dv),
    .Par_Err      (pe_o),
    .Stp_Err      (se_o),
    .Strt_Glitch  (sg_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sampler stand-in: capture the line at mid-bit and hold it until the bit end.
  always @(posedge clk) begin
    if (dse && edge_cnt == (prescale >> 1)) sampled_bit <= rx;
  end

  always @(negedge clk) begin
    if (!rst && (dv || pe_o || se_o || sg_o))
      obs_q.push_back('{cyc: cyc, dv: dv, pe: pe_o, se: se_o, sg: sg_o, pd: p_data});
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic hold_bit(input logic b, input int p);
    @(negedge clk);
    rx = b;
    repeat (p - 1) @(negedge clk);
  endtask

  // Drive one frame; detection happens at the first edge the controller is idle with the line low.
  task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                            input bit flip, input bit stop,
                            input bit exp_dv, input bit exp_pe, input bit exp_se);
    int drop, det, len;
    logic par_bit;
    @(negedge clk);
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = pt;
    rx       = 1'b0;
    drop = cyc + 1;
    det  = (drop > last_end + 1) ? drop : last_end + 1;
    len  = (2 + 8 + (pe ? 1 : 0)) * p;
    last_end = det + len;
    if (exp_dv) last_good = d;
    exp_q.push_back('{cyc: last_end, dv: exp_dv, pe: exp_pe, se: exp_se, sg: 1'b0, pd: last_good});
    repeat (p - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        par_en  = ~pe;
        par_typ = ~pt;
      end
      hold_bit(d[i], p);
    end
    par_bit = (^d) ^ pt ^ flip;
    if (pe) hold_bit(par_bit, p);
    hold_bit(stop, p);
  endtask

  task automatic flush(input string name);
    int n;
    @(negedge clk);
    rx = 1'b1;
    while (cyc < last_end + 3) @(negedge clk);
    check({name, "_evcount"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_event"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int drop;
    int p, gap;
    bit pe, pt, flip, stop;
    logic [7:0] d;

    vecs[0] = '{p: 8,  pe: 0, pt: 0, d: 8'hA5, flip: 0, stop: 1, exp_dv: 1, exp_pe: 0, exp_se: 0};
    vecs[1] = '{p: 16, pe: 1, pt: 0, d: 8'h3C, flip: 0, stop: 1, exp_dv: 1, exp_pe: 0, exp_se: 0};
    vecs[2] = '{p: 16, pe: 1, pt: 0, d: 8'h3C, flip: 1, stop: 1, exp_dv: 0, exp_pe: 1, exp_se: 0};
    vecs[3] = '{p: 8,  pe: 0, pt: 0, d: 8'h81, flip: 0, stop: 0, exp_dv: 0, exp_pe: 0, exp_se: 1};
    vecs[4] = '{p: 8,  pe: 1, pt: 1, d: 8'h81, flip: 1, stop: 0, exp_dv: 0, exp_pe: 1, exp_se: 1};
    vecs[5] = '{p: 32, pe: 1, pt: 1, d: 8'hC3, flip: 0, stop: 1, exp_dv: 1, exp_pe: 0, exp_se: 0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {edge_cnt, dse, p_data, dv, pe_o, se_o, sg_o}, '0);
    rst = 1'b0;
    idle(3);
    last_end = cyc;

    for (int i = 0; i < 6; i++) begin
      idle(2);
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d, vecs[i].flip, vecs[i].stop,
                 vecs[i].exp_dv, vecs[i].exp_pe, vecs[i].exp_se);
      flush($sformatf("vec%0d", i));
    end

    // Start glitch: line low for two cycles only.
    idle(3);
    @(negedge clk);
    prescale = 6'd8;
    rx = 1'b0;
    drop = cyc + 1;
    @(negedge clk);
    check("glitch_samp_en_on", 64'(dse), 64'd1);
    check("glitch_edge0", 64'(edge_cnt), 64'd0);
    @(negedge clk);
    rx = 1'b1;
    check("glitch_edge1", 64'(edge_cnt), 64'd1);
    last_end = drop + 8;
    exp_q.push_back('{cyc: last_end, dv: 1'b0, pe: 1'b0, se: 1'b0, sg: 1'b1, pd: last_good});
    flush("glitch");
    check("glitch_idle", {edge_cnt, dse}, '0);

    // Reset in the middle of data bit 4.
    idle(2);
    @(negedge clk);
    prescale = 6'd8;
    par_en   = 1'b0;
    rx       = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 0; i < 4; i++) hold_bit(1'b1, 8);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midframe_reset", {edge_cnt, dse, p_data, dv, pe_o, se_o, sg_o}, '0);
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    last_good = 8'h00;
    obs_q.delete();
    idle(2);
    last_end = cyc;
    send_frame(8, 0, 0, 8'h5A, 0, 1, 1, 0, 0);
    flush("after_reset");

    // Back-to-back frames at Prescale 32, no idle gap on the line.
    idle(2);
    send_frame(32, 0, 0, 8'h11, 0, 1, 1, 0, 0);
    send_frame(32, 0, 0, 8'hEE, 0, 1, 1, 0, 0);
    flush("back2back");

    // Randomised frames; outcome predicted from parity and stop rules.
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      gap  = $urandom_range(1, 4);
      idle(gap);
      send_frame(p, pe, pt, d, flip, stop,
                 !(pe && flip) && stop, pe && flip, !stop);
      flush($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
